// File: rtl/demux8_stream_if.sv
// Stream-side and channel-side signal bundle of the 1:8 demux scheduler.
// The master drives the input stream and the sink readies. The slave is the scheduler.
interface demux8_stream_if #(
    parameter int W = 1
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [2:0]   in_dest;
    logic         mode;
    logic [7:0]   ch_en;
    logic [7:0]   ch_ready;
    logic [W-1:0] m;
    logic [2:0]   sel;
    logic [7:0]   ch_valid;
    logic         drop;
    logic         no_chan;
    logic [15:0]  tx_count;

    modport master (
        output in_valid, in_data, in_dest, mode, ch_en, ch_ready,
        input  in_ready, m, sel, ch_valid, drop, no_chan, tx_count
    );

    modport slave (
        input  in_valid, in_data, in_dest, mode, ch_en, ch_ready,
        output in_ready, m, sel, ch_valid, drop, no_chan, tx_count
    );
endinterface

// File: rtl/demux8_stream_scheduler.sv
// Steers a valid/ready word stream onto eight demux channels through a one-entry output register.
// Two routing modes: fixed per-word destination, or weighted round-robin over an enable mask.
module demux8_stream_scheduler #(
    parameter int W     = 1,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    demux8_stream_if.slave    bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t       state_r;
    state_t       state_nxt_s;
    logic [W-1:0] m_r;
    logic [2:0]   sel_r;
    logic [7:0]   ch_valid_r;
    logic         drop_r;
    logic [15:0]  tx_count_r;
    logic [2:0]   ptr_r;
    logic [7:0]   burst_r;
    logic         last_mode_r;

    logic         deliver_s;
    logic         no_chan_s;
    logic         in_ready_s;
    logic         accept_s;
    logic         load_s;
    logic         drop_s;
    logic [7:0]   burst_inc_s;
    logic [2:0]   ptr_post_s;
    logic [7:0]   burst_post_s;
    logic [2:0]   dest_s;
    logic [2:0]   ptr_nxt_s;
    logic [7:0]   burst_nxt_s;
    logic         last_mode_nxt_s;

    // Next enabled channel strictly above p (mod 8). It returns p itself when p is the only enabled channel.
    function automatic logic [2:0] next_enabled(input logic [2:0] p, input logic [7:0] en);
        logic [2:0] res;
        logic [2:0] cand;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand  = p + 3'(k);
            res   = (!found && en[cand]) ? cand : res;
            found = found | en[cand];
        end
        return res;
    endfunction

    // Handshake, pointer update from this cycle's delivery, then destination choice for the new word.
    always_comb begin
        deliver_s       = (state_r == FULL) && bus.ch_ready[sel_r];
        no_chan_s       = bus.mode && (bus.ch_en == 8'h00);
        in_ready_s      = rst_n && !no_chan_s && ((state_r == EMPTY) || deliver_s);
        accept_s        = bus.in_valid && in_ready_s;
        burst_inc_s     = burst_r + 8'd1;
        ptr_post_s      = ptr_r;
        burst_post_s    = burst_r;
        dest_s          = bus.in_dest;
        load_s          = 1'b0;
        drop_s          = 1'b0;
        last_mode_nxt_s = last_mode_r;

        if (deliver_s && last_mode_r) begin
            if (burst_inc_s >= 8'(BURST)) begin
                burst_post_s = 8'd0;
                ptr_post_s   = next_enabled(ptr_r, bus.ch_en);
            end else begin
                burst_post_s = burst_inc_s;
            end
        end else begin
            burst_post_s = burst_r;
        end

        ptr_nxt_s   = ptr_post_s;
        burst_nxt_s = burst_post_s;

        if (accept_s) begin
            if (bus.mode) begin
                if (!bus.ch_en[ptr_post_s]) begin
                    dest_s      = next_enabled(ptr_post_s, bus.ch_en);
                    burst_nxt_s = 8'd0;
                end else begin
                    dest_s      = ptr_post_s;
                    burst_nxt_s = last_mode_r ? burst_post_s : 8'd0;
                end
                ptr_nxt_s       = dest_s;
                load_s          = 1'b1;
                last_mode_nxt_s = 1'b1;
            end else if (bus.ch_en[bus.in_dest]) begin
                load_s          = 1'b1;
                burst_nxt_s     = last_mode_r ? 8'd0 : burst_post_s;
                last_mode_nxt_s = 1'b0;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // A same-cycle reload keeps the register FULL with no bubble.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY:   state_nxt_s = load_s ? FULL : EMPTY;
            FULL:    state_nxt_s = load_s ? FULL : (deliver_s ? EMPTY : FULL);
            default: state_nxt_s = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output register, round-robin bookkeeping and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r         <= '0;
            sel_r       <= 3'd0;
            ch_valid_r  <= 8'h00;
            drop_r      <= 1'b0;
            tx_count_r  <= 16'd0;
            ptr_r       <= 3'd0;
            burst_r     <= 8'd0;
            last_mode_r <= 1'b0;
        end else begin
            if (load_s) begin
                m_r        <= bus.in_data;
                sel_r      <= dest_s;
                ch_valid_r <= 8'd1 << dest_s;
            end else if (deliver_s) begin
                ch_valid_r <= 8'h00;
            end else begin
                ch_valid_r <= ch_valid_r;
            end
            drop_r      <= drop_s;
            tx_count_r  <= tx_count_r + {15'd0, deliver_s};
            ptr_r       <= ptr_nxt_s;
            burst_r     <= burst_nxt_s;
            last_mode_r <= last_mode_nxt_s;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.no_chan  = no_chan_s;
    assign bus.m        = m_r;
    assign bus.sel      = sel_r;
    assign bus.ch_valid = ch_valid_r;
    assign bus.drop     = drop_r;
    assign bus.tx_count = tx_count_r;
endmodule

// File: tb/tb_demux8_stream_scheduler.sv
// Directed bench for demux8_stream_scheduler: reset, fixed routing, drop, round-robin bursts,
// backpressure, empty enable mask and asynchronous reset while a word is held.
module tb_demux8_stream_scheduler;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   rr_exp [17] = '{0, 0, 0, 0, 2, 2, 2, 2, 5, 5, 5, 5, 7, 7, 7, 7, 0};

    demux8_stream_if #(.W(1)) bus ();

    demux8_stream_scheduler #(.W(1), .BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        bus.in_dest  = 3'd0;
        bus.mode     = 1'b0;
        bus.ch_en    = 8'hFF;
        bus.ch_ready = 8'hFF;

        // Reset held with in_valid=1
        #12;
        chk("rst_ch_valid", 32'(bus.ch_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_tx_count", 32'(bus.tx_count), 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_m", 32'(bus.m), 32'h0);
        #10;
        rst_n = 1'b1;

        // Fixed mode, destinations 0..7 back to back
        for (int d = 0; d < 8; d++) begin
            step();
            chk("fix_ch_valid", 32'(bus.ch_valid), 32'(1) << d);
            chk("fix_sel", 32'(bus.sel), 32'(d));
            chk("fix_m", 32'(bus.m), 32'h1);
            chk("fix_tx_count", 32'(bus.tx_count), 32'(d));
            if (d == 7) bus.in_valid = 1'b0;
            else        bus.in_dest  = 3'(d + 1);
        end
        step();
        chk("fix_tx_final", 32'(bus.tx_count), 32'd8);
        chk("fix_empty", 32'(bus.ch_valid), 32'h0);

        // Fixed mode drop on disabled channel 0, then channel 3
        bus.ch_en    = 8'hFE;
        bus.in_dest  = 3'd0;
        bus.in_valid = 1'b1;
        step();
        chk("drop_pulse", 32'(bus.drop), 32'h1);
        chk("drop_ch_valid", 32'(bus.ch_valid), 32'h0);
        chk("drop_tx_count", 32'(bus.tx_count), 32'd8);
        bus.in_dest = 3'd3;
        step();
        chk("drop_clear", 32'(bus.drop), 32'h0);
        chk("drop_next_ch_valid", 32'(bus.ch_valid), 32'h08);
        chk("drop_next_sel", 32'(bus.sel), 32'd3);
        bus.in_valid = 1'b0;
        step();
        chk("drop_tx_after", 32'(bus.tx_count), 32'd9);

        // Round-robin, BURST=4, mask 1010_0101, 17 words
        bus.mode     = 1'b1;
        bus.ch_en    = 8'b1010_0101;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            chk("rr_sel", 32'(bus.sel), 32'(rr_exp[i]));
            chk("rr_ch_valid", 32'(bus.ch_valid), 32'(1) << rr_exp[i]);
            chk("rr_tx_count", 32'(bus.tx_count), 32'(9 + i));
            if (i == 16) bus.in_valid = 1'b0;
        end
        step();
        chk("rr_tx_final", 32'(bus.tx_count), 32'd26);
        chk("rr_empty", 32'(bus.ch_valid), 32'h0);

        // Backpressure on channel 2; other sinks ready but must be ignored
        bus.ch_en    = 8'h04;
        bus.ch_ready = 8'hFB;
        bus.in_data  = 1'b1;
        bus.in_valid = 1'b1;
        step();
        chk("bp_load_sel", 32'(bus.sel), 32'd2);
        bus.in_data = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_sel", 32'(bus.sel), 32'd2);
            chk("bp_ch_valid", 32'(bus.ch_valid), 32'h04);
            chk("bp_m", 32'(bus.m), 32'h1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
            chk("bp_tx_count", 32'(bus.tx_count), 32'd26);
        end
        bus.ch_ready = 8'hFF;
        #1;
        chk("bp_pass_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk("bp_reload_ch_valid", 32'(bus.ch_valid), 32'h04);
        chk("bp_reload_m", 32'(bus.m), 32'h0);
        chk("bp_reload_tx", 32'(bus.tx_count), 32'd27);
        bus.in_valid = 1'b0;
        step();
        chk("bp_tx_final", 32'(bus.tx_count), 32'd28);

        // Round-robin with empty mask, then only channel 6
        bus.ch_en    = 8'h00;
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        #1;
        chk("nc_no_chan", 32'(bus.no_chan), 32'h1);
        chk("nc_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        chk("nc_ch_valid", 32'(bus.ch_valid), 32'h0);
        chk("nc_tx_count", 32'(bus.tx_count), 32'd28);
        bus.ch_en = 8'h40;
        #1;
        chk("nc_no_chan_off", 32'(bus.no_chan), 32'h0);
        chk("nc_in_ready_on", 32'(bus.in_ready), 32'h1);
        bus.ch_ready = 8'h00;
        step();
        chk("nc_sel", 32'(bus.sel), 32'd6);
        chk("nc_ch_valid_on", 32'(bus.ch_valid), 32'h40);
        bus.in_valid = 1'b0;

        // Asynchronous reset while a word is held
        step();
        chk("mid_held", 32'(bus.ch_valid), 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ch_valid", 32'(bus.ch_valid), 32'h0);
        chk("mid_rst_tx_count", 32'(bus.tx_count), 32'h0);
        chk("mid_rst_sel", 32'(bus.sel), 32'h0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        #10;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
